// File: rtl/ghr_ckpt_queue.sv
// ghr_ckpt_queue: a circular store of GHR snapshots, one per in-flight
// predicted branch. On a mispredict it repairs the GHR (snapshot shifted left
// with the actual outcome) and drops every checkpoint younger than the branch.
module ghr_ckpt_queue #(
    parameter int DEPTH = 16,
    parameter int GHR_W = 32,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_valid,
    input  logic [GHR_W-1:0] alloc_ghr,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             resolve_valid,
    input  logic [TAG_W-1:0] resolve_tag,
    input  logic             resolve_mispredict,
    input  logic             resolve_taken,
    input  logic             commit_valid,
    input  logic             flush,
    output logic             ghr_wen,
    output logic [GHR_W-1:0] ghr_wdata,
    output logic [TAG_W:0]   count,
    output logic             empty,
    output logic             full
);

    logic [GHR_W-1:0] snap [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [TAG_W-1:0] resolve_dist;
    logic             mispredict_hit;
    logic             alloc_fire;
    logic             commit_fire;

    assign full           = (count == (TAG_W+1)'(DEPTH));
    assign empty          = (count == '0);
    assign alloc_ready    = !full && !flush && !(resolve_valid && resolve_mispredict);
    assign alloc_tag      = tail;
    assign alloc_fire     = alloc_valid && alloc_ready;
    assign commit_fire    = commit_valid && valid_q[head];
    assign mispredict_hit = resolve_valid && resolve_mispredict && valid_q[resolve_tag];
    assign resolve_dist   = resolve_tag - head;

    // Next valid vector: a mispredict drops entries further from head than the resolved one
    always_comb begin
        valid_d = valid_q;
        if (mispredict_hit) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (TAG_W'(TAG_W'(i) - head) > resolve_dist) begin
                    valid_d[i] = 1'b0;
                end
            end
        end
        if (commit_fire) begin
            valid_d[head] = 1'b0;
        end
        if (alloc_fire) begin
            valid_d[tail] = 1'b1;
        end
    end

    // Snapshot storage needs no reset; entries are only read while valid
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            snap[tail] <= alloc_ghr;
        end
    end

    // Pointers, occupancy and valid bits with flush > mispredict > alloc priority
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            valid_q <= '0;
        end else if (flush) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
            if (commit_fire) begin
                head <= head + 1'b1;
            end
            if (mispredict_hit) begin
                tail  <= resolve_tag + 1'b1;
                count <= {1'b0, resolve_dist} + (TAG_W+1)'(1) - (TAG_W+1)'(commit_fire);
            end else begin
                if (alloc_fire) begin
                    tail <= tail + 1'b1;
                end
                count <= count + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(commit_fire);
            end
        end
    end

    // Registered GHR repair: one-cycle pulse carrying the shifted snapshot plus the real outcome
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr_wen   <= 1'b0;
            ghr_wdata <= '0;
        end else if (flush) begin
            ghr_wen   <= 1'b0;
        end else if (mispredict_hit) begin
            ghr_wen   <= 1'b1;
            ghr_wdata <= {snap[resolve_tag][GHR_W-2:0], resolve_taken};
        end else begin
            ghr_wen   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ghr_ckpt_queue.sv
// tb_ghr_ckpt_queue: drives directed and random alloc/resolve/commit/flush
// traffic into a DEPTH=4 queue. A reference model keeps the live checkpoints
// as an ordered list; expected GHR repairs go into a scoreboard queue that a
// separate monitor drains whenever the DUT pulses ghr_wen.
module tb_ghr_ckpt_queue;

    localparam int DEPTH = 4;
    localparam int GHR_W = 32;
    localparam int TAG_W = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             alloc_valid = 1'b0;
    logic [GHR_W-1:0] alloc_ghr = '0;
    logic             alloc_ready;
    logic [TAG_W-1:0] alloc_tag;
    logic             resolve_valid = 1'b0;
    logic [TAG_W-1:0] resolve_tag = '0;
    logic             resolve_mispredict = 1'b0;
    logic             resolve_taken = 1'b0;
    logic             commit_valid = 1'b0;
    logic             flush = 1'b0;
    logic             ghr_wen;
    logic [GHR_W-1:0] ghr_wdata;
    logic [TAG_W:0]   count;
    logic             empty;
    logic             full;

    int n_checks = 0;
    int n_fails  = 0;

    logic [GHR_W-1:0] model_q [$];
    int               head_tag = 0;
    logic [GHR_W-1:0] exp_q [$];
    logic [GHR_W-1:0] last_data = '0;

    ghr_ckpt_queue #(.DEPTH(DEPTH), .GHR_W(GHR_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .alloc_valid       (alloc_valid),
        .alloc_ghr         (alloc_ghr),
        .alloc_ready       (alloc_ready),
        .alloc_tag         (alloc_tag),
        .resolve_valid     (resolve_valid),
        .resolve_tag       (resolve_tag),
        .resolve_mispredict(resolve_mispredict),
        .resolve_taken     (resolve_taken),
        .commit_valid      (commit_valid),
        .flush             (flush),
        .ghr_wen           (ghr_wen),
        .ghr_wdata         (ghr_wdata),
        .count             (count),
        .empty             (empty),
        .full              (full)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    task automatic compareValue(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Compare occupancy and handshake outputs against the model for the inputs now applied
    task automatic checkOutput();
        int   sz;
        logic exp_ready;
        sz        = model_q.size();
        exp_ready = (sz < DEPTH) && !flush && !(resolve_valid && resolve_mispredict);
        compareValue("count",       64'(count),       64'(sz));
        compareValue("empty",       64'(empty),       64'(sz == 0));
        compareValue("full",        64'(full),        64'(sz == DEPTH));
        compareValue("alloc_ready", 64'(alloc_ready), 64'(exp_ready));
        compareValue("alloc_tag",   64'(alloc_tag),   64'((head_tag + sz) % DEPTH));
    endtask

    // Drive one cycle of inputs, check, then advance the model across the clock edge
    task automatic applyStimulus(input logic av, input logic [GHR_W-1:0] ag,
                                 input logic rv, input logic [TAG_W-1:0] rtag,
                                 input logic rm, input logic rt,
                                 input logic cv, input logic fl);
        int               sz;
        int               k;
        logic             rdy;
        logic [GHR_W-1:0] s;
        @(negedge clk);
        alloc_valid        = av;
        alloc_ghr          = ag;
        resolve_valid      = rv;
        resolve_tag        = rtag;
        resolve_mispredict = rm;
        resolve_taken      = rt;
        commit_valid       = cv;
        flush              = fl;
        #1;
        checkOutput();
        sz  = model_q.size();
        rdy = (sz < DEPTH) && !fl && !(rv && rm);
        @(posedge clk);
        if (fl) begin
            model_q.delete();
            head_tag = 0;
        end else begin
            if (rv && rm) begin
                k = (int'(rtag) - head_tag + DEPTH) % DEPTH;
                if (k < sz) begin
                    s = model_q[k];
                    while (model_q.size() > k + 1) begin
                        void'(model_q.pop_back());
                    end
                    exp_q.push_back({s[GHR_W-2:0], rt});
                end
            end else if (av && rdy) begin
                model_q.push_back(ag);
            end
            if (cv && sz > 0) begin
                void'(model_q.pop_front());
                head_tag = (head_tag + 1) % DEPTH;
            end
        end
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset in the middle of a cycle, checked before any clock edge
    task automatic doReset();
        @(negedge clk);
        #2;
        rst                = 1'b0;
        alloc_valid        = 1'b0;
        resolve_valid      = 1'b0;
        resolve_mispredict = 1'b0;
        commit_valid       = 1'b0;
        flush              = 1'b0;
        #1;
        compareValue("reset_count",   64'(count),   64'(0));
        compareValue("reset_empty",   64'(empty),   64'(1));
        compareValue("reset_ghr_wen", 64'(ghr_wen), 64'(0));
        model_q.delete();
        exp_q.delete();
        head_tag  = 0;
        last_data = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Monitor: whenever the DUT pulses ghr_wen, pop the scoreboard and compare
    initial begin
        logic [GHR_W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (ghr_wen === 1'b1 || exp_q.size() != 0) begin
                if (exp_q.size() == 0) begin
                    compareValue("ghr_wen_spurious", 64'(ghr_wen), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    compareValue("ghr_wen",   64'(ghr_wen),   64'(1));
                    compareValue("ghr_wdata", 64'(ghr_wdata), 64'(e));
                    last_data = e;
                end
            end else begin
                compareValue("ghr_wdata_hold", 64'(ghr_wdata), 64'(last_data));
            end
        end
    end

    // Watchdog so a stuck run still ends with a report
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by random traffic
    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idleCycle();

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h11 * (i + 1), 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 32'h55, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h66, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h77, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        idleCycle();

        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h0000_00F0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0000_0A01, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0000_0B02, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        compareValue("restore_pulse", 64'(ghr_wen),   64'(1));
        compareValue("restore_value", 64'(ghr_wdata), 64'h0000_01E1);
        idleCycle();
        idleCycle();

        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, $urandom, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, $urandom, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, '0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        idleCycle();

        applyStimulus(1'b1, 32'hCAFE_0001, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hCAFE_0002, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        idleCycle();

        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'hBEEF_0001, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        idleCycle();

        applyStimulus(1'b1, 32'hBEEF_0002, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hBEEF_0003, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        doReset();
        idleCycle();

        for (int n = 0; n < 1500; n++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom,
                          $urandom_range(0, 3) == 0, TAG_W'($urandom_range(0, DEPTH - 1)),
                          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0);
        end
        idleCycle();
        idleCycle();
        compareValue("pending_restores", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/ghr_ckpt_queue.md
Name: ghr_ckpt_queue

Overview:
- Checkpoint store for the global history register (GHR) on the restore side.
- At each predicted branch, the frontend allocates an entry holding the GHR value as it stood before that branch's speculative shift.
- On a branch mispredict, the block drives the GHR write port with the repaired history: snapshot shifted left, actual outcome in the LSB. It also squashes all younger checkpoints.
- Sits beside the GHR in the frontend and is fed by fetch (allocate), branch resolution (resolve) and ROB (commit/flush).

Parameters:
- DEPTH, 16: number of checkpoint entries. Must be a power of two, at least 2.
- GHR_W, 32: GHR width.
- TAG_W, $clog2(DEPTH): derived; width of the entry tag.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- alloc_valid  in  1  fetch requests a checkpoint.
- alloc_ghr  in  GHR_W  GHR value before this branch's speculative shift.
- alloc_ready  out  1  checkpoint can be accepted this cycle.
- alloc_tag  out  TAG_W  tag assigned to the accepted entry (= tail).
- resolve_valid  in  1  a branch resolved this cycle.
- resolve_tag  in  TAG_W  tag of the resolved branch.
- resolve_mispredict  in  1  resolved direction differs from the prediction.
- resolve_taken  in  1  actual branch direction.
- commit_valid  in  1  the oldest checkpoint's branch retired.
- flush  in  1  full pipeline flush; discard all entries, no GHR write.
- ghr_wen  out  1  GHR restore strobe.
- ghr_wdata  out  GHR_W  repaired GHR value.
- count  out  TAG_W+1  live entries.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.

Behaviour:
- Storage and pointers:
  - Circular buffer: snap[DEPTH], valid[DEPTH], head (oldest), tail (next free), count.
  - Pointers wrap modulo DEPTH.
- Reset (asynchronous, rst=0): head=tail=count=0, all valid=0, ghr_wen=0, ghr_wdata=0. Snapshot contents are don't-care.
- Handshakes:
  - alloc_ready = !full && !flush && !(resolve_valid && resolve_mispredict); combinational.
  - alloc_tag = tail; combinational.
  - Allocation fires when alloc_valid && alloc_ready: snap[tail] <= alloc_ghr, valid[tail] <= 1, tail+1.
- Commit:
  - When commit_valid && valid[head]: valid[head] <= 0, head+1.
  - commit_valid with the queue empty is ignored; no state change.
- Correct resolve (resolve_mispredict=0): no state change. The entry stays until commit.
- Mispredict (resolve_valid && resolve_mispredict && valid[resolve_tag]):
  - Clear valid for every entry strictly younger than resolve_tag (from resolve_tag+1 up to tail-1, wrapping).
  - tail <= resolve_tag+1.
  - count <= ((resolve_tag - head) mod DEPTH) + 1, minus 1 if a commit fires the same cycle.
  - The resolved entry itself is kept until it commits.
  - A mispredict on an invalid tag is ignored.
- Restore output:
  - Registered, 1-cycle latency.
  - Cycle after a qualifying mispredict: ghr_wen=1, ghr_wdata = {snap[resolve_tag][GHR_W-2:0], resolve_taken}.
  - Otherwise ghr_wen=0 and ghr_wdata holds its last value.
  - ghr_wen is a single-cycle pulse per mispredict.
- Flush: clears all valid bits, head=tail=count=0, ghr_wen=0 next cycle.
- Priority: flush > mispredict > alloc.
  - Commit is independent of mispredict and applies in the same cycle.
  - Commit and mispredict on the same tag (head) are legal: the restore still fires and the entry frees.
- Simultaneous alloc + commit with the queue full: no alloc (alloc_ready=0 while full); the commit proceeds.
- At most one resolve per cycle.

Test Plan:
- Reset (DEPTH=4): rst=0 mid-operation with 3 live entries -> immediately count=0, empty=1, ghr_wen=0; after release alloc_tag=0.
- Fill/full: 4 allocs with ghr 0x11, 0x22, 0x33, 0x44 -> tags 0..3, full=1, alloc_ready=0; a 5th alloc_valid is not accepted; commit -> count=3, next alloc gets tag 0 (wrap).
- Mispredict restore: entries tag0=0x0000_00F0, tag1, tag2; resolve tag0 mispredict taken=1 -> next cycle ghr_wen=1, ghr_wdata=0x0000_01E1; count=1, tail=1, alloc_tag=1.
- Wrapped squash: head=3, entries at tags 3,0,1; mispredict on tag 0 with commit_valid same cycle -> count=1, head=0, tail=1, valid[1]=0.
- Priority: flush together with a mispredict and alloc_valid -> no ghr_wen pulse, count=0, alloc not accepted.
- Ignored events: commit on empty, mispredict on a stale tag, correct resolve -> no state change, ghr_wen stays 0.
